// File: rtl/matrix_mac_stream.sv
// Streaming SIZE x SIZE matrix multiplier: loads A then B row-major, computes C = A*B
// with a single two-stage multiply-accumulate pipeline, then streams C out row-major.
module matrix_mac_stream #(
  parameter int unsigned SIZE = 4,
  parameter int unsigned DW   = 8,
  localparam int unsigned ACCW = 2*DW + $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sgn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data,
  output logic            busy,
  output logic            done
);

  localparam int unsigned IW    = $clog2(SIZE);
  localparam int unsigned PW    = 2*DW;
  localparam int unsigned EXTW  = ACCW - PW;
  localparam int unsigned NCUBE = SIZE*SIZE*SIZE;
  localparam int unsigned CW    = $clog2(NCUBE + 2);
  localparam int unsigned LAST  = SIZE - 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;

  state_t state_q, state_d;

  // Operand and result storage; deliberately not reset.
  logic [DW-1:0]   a_mem [SIZE][SIZE];
  logic [DW-1:0]   b_mem [SIZE][SIZE];
  logic [ACCW-1:0] c_mem [SIZE][SIZE];

  logic          sgn_q;
  logic [IW-1:0] ld_row, ld_col;
  logic          ld_sel;
  logic [IW-1:0] ci, cj, ck;
  logic [CW-1:0] comp_cnt;
  logic [IW-1:0] out_row, out_col;

  // Pipeline stage 1: product plus the tags describing where it belongs.
  logic [PW-1:0] p_q;
  logic          s1_valid, s1_first, s1_last;
  logic [IW-1:0] s1_i, s1_j;

  // Pipeline stage 2 accumulator.
  logic [ACCW-1:0] acc;

  logic            in_fire, out_fire;
  logic            ld_last, out_last;
  logic            issue, comp_end;
  logic [DW-1:0]   a_el, b_el;
  logic [PW-1:0]   mul_a, mul_b, mul_p;
  logic [ACCW-1:0] p_ext, acc_next;
  logic [IW-1:0]   out_row_n, out_col_n;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(LAST)) ? '0 : v + IW'(1);
  endfunction

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign ld_last  = ld_sel & (ld_row == IW'(LAST)) & (ld_col == IW'(LAST));
  assign out_last = (out_row == IW'(LAST)) & (out_col == IW'(LAST));
  assign issue    = (state_q == COMP) & (comp_cnt < CW'(NCUBE));
  assign comp_end = (state_q == COMP) & (comp_cnt == CW'(NCUBE + 1));

  // Operands are sign- or zero-extended to full product width, so the low PW bits are exact.
  assign a_el  = a_mem[ci][ck];
  assign b_el  = b_mem[ck][cj];
  assign mul_a = {{DW{sgn_q & a_el[DW-1]}}, a_el};
  assign mul_b = {{DW{sgn_q & b_el[DW-1]}}, b_el};
  assign mul_p = mul_a * mul_b;

  assign p_ext    = {{EXTW{sgn_q & p_q[PW-1]}}, p_q};
  assign acc_next = s1_first ? p_ext : acc + p_ext;

  assign out_col_n = wrap_inc(out_col);
  assign out_row_n = (out_col == IW'(LAST)) ? wrap_inc(out_row) : out_row;

  // Next-state logic and the same-cycle completion strobe.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (in_fire && ld_last) state_d = COMP;
      COMP: if (comp_end) state_d = OUT;
      OUT: begin
        if (out_fire && out_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      sgn_q     <= 1'b0;
      ld_row    <= '0;
      ld_col    <= '0;
      ld_sel    <= 1'b0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
      comp_cnt  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      p_q       <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_i      <= '0;
      s1_j      <= '0;
      acc       <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == LOAD);
      out_valid <= (state_d == OUT);
      busy      <= (state_d != IDLE);

      if (state_q == IDLE && start) begin
        sgn_q    <= sgn;
        ld_row   <= '0;
        ld_col   <= '0;
        ld_sel   <= 1'b0;
        ci       <= '0;
        cj       <= '0;
        ck       <= '0;
        comp_cnt <= '0;
      end

      if (in_fire) begin
        ld_col <= wrap_inc(ld_col);
        if (ld_col == IW'(LAST)) begin
          ld_row <= wrap_inc(ld_row);
          if (ld_row == IW'(LAST)) ld_sel <= ~ld_sel;
        end
      end

      if (state_q == COMP) comp_cnt <= comp_end ? '0 : comp_cnt + CW'(1);

      // Index walk: k innermost, then j, then i.
      if (issue) begin
        ck <= wrap_inc(ck);
        if (ck == IW'(LAST)) begin
          cj <= wrap_inc(cj);
          if (cj == IW'(LAST)) ci <= wrap_inc(ci);
        end
      end

      s1_valid <= issue;
      if (issue) begin
        p_q      <= mul_p;
        s1_first <= (ck == '0);
        s1_last  <= (ck == IW'(LAST));
        s1_i     <= ci;
        s1_j     <= cj;
      end

      if (s1_valid) acc <= acc_next;

      if (comp_end) begin
        out_row  <= '0;
        out_col  <= '0;
        out_data <= c_mem[0][0];
      end else if (out_fire && !out_last) begin
        out_row  <= out_row_n;
        out_col  <= out_col_n;
        out_data <= c_mem[out_row_n][out_col_n];
      end
    end
  end

  // Storage writes: operands during LOAD, finished sums from pipeline stage 2.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (!ld_sel) a_mem[ld_row][ld_col] <= in_data;
      else         b_mem[ld_row][ld_col] <= in_data;
    end
    if (s1_valid && s1_last) c_mem[s1_i][s1_j] <= acc_next;
  end

endmodule

// File: tb/tb_matrix_mac_stream.sv
// Self-checking bench for matrix_mac_stream (SIZE=4, DW=8): directed and random
// operand sets compared element by element against an integer matrix-product model.
module tb_matrix_mac_stream;

  localparam int NE = 16;

  logic        clk, reset, start, sgn, in_valid, in_ready;
  logic        out_valid, out_ready, busy, done;
  logic [7:0]  in_data;
  logic [17:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  ma    [NE];
  logic [7:0]  mb    [NE];
  logic [17:0] exp_c [NE];
  logic [17:0] last_out;

  matrix_mac_stream #(.SIZE(4), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sgn       (sgn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int opv(input logic [7:0] v, input bit s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  // Reference: plain integer matrix product, reduced to 18-bit two's complement.
  task automatic model(input bit s);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int sum;
        sum = 0;
        for (int k = 0; k < 4; k++) sum += opv(ma[i*4+k], s) * opv(mb[k*4+j], s);
        exp_c[i*4+j] = 18'(sum);
      end
    end
  endtask

  task automatic fill_random();
    for (int e = 0; e < NE; e++) begin
      ma[e] = 8'($urandom);
      mb[e] = 8'($urandom);
    end
  endtask

  task automatic run_job(input bit s, input int gap_pct, input bit stall, input bit spam,
                         input bit chk_lat);
    int idx, lat, n, guard;
    logic [17:0] held;
    bit prev_stall;
    model(s);
    start = 1'b1; sgn = s; in_valid = 1'b0;
    tick();
    lat = 1;
    start = 1'b0; sgn = ~s;
    chk("busy_on", 32'(busy), 32'd1);
    chk("in_ready_on", 32'(in_ready), 32'd1);

    idx = 0; guard = 0;
    while (idx < 32 && guard < 2000) begin
      in_valid = ($urandom_range(99) >= 32'(gap_pct));
      in_data  = (idx < 16) ? ma[idx] : mb[idx-16];
      if (spam) start = 1'($urandom_range(1));
      #1;
      chk("load_excl", 32'(in_ready & out_valid), 32'd0);
      if (in_valid && in_ready) idx++;
      tick(); lat++; guard++;
    end
    chk("load_count", 32'(idx), 32'd32);
    in_valid = 1'b0;
    chk("in_ready_drop", 32'(in_ready), 32'd0);

    guard = 0;
    while (!out_valid && guard < 300) begin
      if (spam) start = 1'($urandom_range(1));
      chk("comp_busy", 32'(busy), 32'd1);
      chk("comp_ready", 32'(in_ready), 32'd0);
      tick(); lat++; guard++;
    end
    chk("out_reached", 32'(out_valid), 32'd1);
    if (chk_lat) chk("latency", 32'(lat), 32'd99);

    n = 0; guard = 0; prev_stall = 0; held = '0;
    while (n < 16 && guard < 500) begin
      out_ready = stall ? ((cyc / 3) % 2 == 0) : 1'b1;
      if (spam) start = 1'($urandom_range(1));
      #1;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_excl", 32'(in_ready), 32'd0);
      chk("out_busy", 32'(busy), 32'd1);
      if (prev_stall) chk("hold", 32'(out_data), 32'(held));
      chk("done", 32'(done), 32'(out_ready && n == 15));
      if (out_ready) begin
        chk($sformatf("c%0d", n), 32'(out_data), 32'(exp_c[n]));
        last_out = out_data;
        n++;
      end
      prev_stall = !out_ready;
      held = out_data;
      tick(); guard++;
    end
    chk("out_count", 32'(n), 32'd16);

    start = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    for (int t = 0; t < 3; t++) begin
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      tick();
    end
  endtask

  task automatic abort_load(input int n);
    start = 1'b1; sgn = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < n; t++) begin
      in_data = 8'($urandom);
      tick();
    end
    chk("mid_load_ready", 32'(in_ready), 32'd1);
    reset = 1'b0; start = 1'b1; out_ready = 1'b1;
    tick();
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("idle_ov", 32'(out_valid), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sgn = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // Identity times B[i][j] = 4i+j, with latency check.
    for (int e = 0; e < NE; e++) begin
      ma[e] = ((e / 4) == (e % 4)) ? 8'd1 : 8'd0;
      mb[e] = 8'(e);
    end
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // -1 * 2 summed four times, signed.
    for (int e = 0; e < NE; e++) begin
      ma[e] = 8'hFF;
      mb[e] = 8'h02;
    end
    run_job(1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("neg8", 32'(last_out), 32'h3FFF8);

    // Largest unsigned operands.
    for (int e = 0; e < NE; e++) begin
      ma[e] = 8'hFF;
      mb[e] = 8'hFF;
    end
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("maxu", 32'(last_out), 32'h3F804);

    // Input gaps and periodic output back-pressure.
    fill_random();
    run_job(1'b1, 40, 1'b1, 1'b0, 1'b0);
    fill_random();
    run_job(1'b0, 40, 1'b1, 1'b0, 1'b0);

    // Abort mid-load, then a fresh complete run.
    abort_load(10);
    fill_random();
    run_job(1'b1, 0, 1'b1, 1'b0, 1'b0);

    // Spurious start pulses throughout a run.
    fill_random();
    run_job(1'b0, 0, 1'b0, 1'b1, 1'b1);
    fill_random();
    run_job(1'b1, 0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_mac_stream.md
MATRIX_MAC_STREAM -- requirements
Module: matrix_mac_stream

Interface
REQ-001 Parameter SIZE, default 4, matrix dimension (SIZE x SIZE), legal range 2..16.
REQ-002 Parameter DW, default 8, operand element width in bits.
REQ-003 Derived parameter ACCW = 2*DW + clog2(SIZE), result element width; not user-overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-006 start  input  1  request a new multiplication; honoured only in IDLE.
REQ-007 sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the accepted start.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DW  operand element; A row-major, then B row-major.
REQ-011 out_valid  output  1  out_data holds a valid C element.
REQ-012 out_ready  input  1  sink accepts out_data this cycle.
REQ-013 out_data  output  ACCW  result element; C row-major; sign-extended when sgn=1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on the last output transfer.

Function
REQ-016 The FSM shall have the states IDLE, LOAD, COMP and OUT.
REQ-017 In IDLE with start=1, the block shall latch sgn, clear the element counters and enter LOAD on the next cycle.
REQ-018 start shall be ignored in LOAD, COMP and OUT.
REQ-019 In LOAD, in_ready shall be 1, and a transfer occurs on each cycle with in_valid & in_ready.
REQ-020 Transfers 0..SIZE^2-1 shall fill A[i][j]; transfers SIZE^2..2*SIZE^2-1 shall fill B[i][j].
REQ-021 Cycles with in_valid=0 in LOAD shall leave the counters unchanged; there shall be no timeout.
REQ-022 On the 2*SIZE^2-th transfer, in_ready shall drop on the following cycle and the FSM shall enter COMP.
REQ-023 COMP shall use one multiplier with a two-stage pipeline.
REQ-024 Pipeline stage 1: product register P = A[i][k]*B[k][j], computed at full 2*DW width and signed or unsigned per the latched sgn.
REQ-025 Pipeline stage 2: an ACCW-bit accumulator, loaded with P when k=0 and incremented by P otherwise.
REQ-026 The index order shall be k innermost, then j, then i; one (i,j,k) issue per cycle.
REQ-027 COMP shall last exactly SIZE^3+2 cycles, including pipeline drain.
REQ-028 Each completed accumulation shall be written to C[i][j].
REQ-029 Arithmetic shall be exact: no overflow is possible within ACCW, and no saturation or truncation shall occur.
REQ-030 In OUT, out_valid shall be 1 with out_data=C[0][0] on the first OUT cycle.
REQ-031 out_data and out_valid shall be held stable while out_valid & !out_ready.
REQ-032 Each out_valid & out_ready transfer shall advance to the next element on the next cycle.
REQ-033 On the SIZE^2-th output transfer, done shall be 1 in that same cycle, and the FSM shall return to IDLE on the next cycle with out_valid=0.
REQ-034 start asserted in the cycle done=1 shall be ignored; the next start is accepted once the FSM is in IDLE.
REQ-035 The latency from the accepted start to the first out_valid shall be 2*SIZE^2 + SIZE^3 + 3 cycles when in_valid is continuously 1.
REQ-036 in_ready and out_valid shall never be high in the same cycle.

Reset
REQ-037 With reset=0 at a rising edge, the FSM shall go to IDLE from any state, including mid-LOAD, mid-COMP and mid-OUT.
REQ-038 Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, all counters=0, accumulator=0, latched sgn=0.
REQ-039 The A, B and C storage arrays need not be cleared by reset.
REQ-040 No output shall be driven from storage data of an aborted run.
REQ-041 Reset shall have priority over start and over all handshakes in the same cycle.

Verification (SIZE=4, DW=8, ACCW=18)
REQ-042 Bench shall cover: A=identity, B[i][j]=4i+j, sgn=0, continuous valid/ready -> C equals B; first out_valid at cycle 99 after the accepted start; done pulses once.
REQ-043 Bench shall cover: A all 0xFF, B all 0x02, sgn=1 -> every out_data=0x3FFF8 (-8).
REQ-044 Bench shall cover: A and B all 0xFF, sgn=0 -> every out_data=0x3F804 (260100), with no overflow.
REQ-045 Bench shall cover: random in_valid gaps plus out_ready toggling every 3 cycles -> out_data stable while stalled, C matches the reference model, and exactly 16 output transfers.
REQ-046 Bench shall cover: reset=0 after 10 LOAD transfers, then a fresh start and a full load -> the result is correct for the new operands only, with no spurious out_valid or done.
REQ-047 Bench shall cover: start pulsed during LOAD, COMP and OUT -> no effect on counters or results; busy stays 1 until the cycle after done.
